rst_sequencer: RTL and testbench

RST_SEQUENCER -- requirements
Module: rst_sequencer

---
 rtl/rst_seq_pkg.sv | 13 +
 rtl/rst_sync.sv | 21 ++
 rtl/rst_sequencer.sv | 135 +++++++++++++
 tb/tb_rst_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// rst_seq_pkg: shared state type and synchronizer depth for the reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RELEASE,
        RUN,
        SOFT_HOLD
    } rst_seq_state_e;

    localparam int RST_SYNC_STAGES = 2;

endpackage

// File: rtl/rst_sync.sv
// rst_sync: reset synchronizer, asserts asynchronously and deasserts after RST_SYNC_STAGES clocks.
module rst_sync
    import rst_seq_pkg::*;
(
    input  logic clock,
    input  logic rst_n,
    output logic rst_n_sync
);

    logic [RST_SYNC_STAGES-1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[RST_SYNC_STAGES-2:0], 1'b1};

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else        sync_q <= sync_d;
    end

    assign rst_n_sync = sync_q[RST_SYNC_STAGES-1];

endmodule

// File: rtl/rst_sequencer.sv
// rst_sequencer: lock-filtered, staggered release of per-stage resets with soft-reset hold.
// Optional lock watchdog enabled by defining RST_SEQ_WATCHDOG_EN.
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_DLY  = 16,
    parameter int LOCK_FILT  = 8,
    parameter int WDOG_CYC   = 100000
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  locked,
    input  logic                  soft_rst_req,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  ready,
    output logic                  lock_timeout
);

    localparam int DW = $clog2(STAGE_DLY + 1);
    localparam int FW = $clog2(LOCK_FILT + 1);
    localparam logic [DW-1:0] DLY_MAX  = DW'(STAGE_DLY);
    localparam logic [FW-1:0] FILT_MAX = FW'(LOCK_FILT);

    logic rst_s_n;

    rst_sync u_rst_sync (
        .clock      (clock),
        .rst_n      (rst_n),
        .rst_n_sync (rst_s_n)
    );

    logic [RST_SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
    rst_seq_state_e             state_q, state_d;
    logic [FW-1:0]              filt_q, filt_d;
    logic [DW-1:0]              dly_q, dly_d;
    logic [NUM_STAGES-1:0]      stage_q, stage_d;
    logic                       lock_s;

    assign lock_s = lock_sync_q[RST_SYNC_STAGES-1];

    always_comb begin
        lock_sync_d = {lock_sync_q[RST_SYNC_STAGES-2:0], locked};
        state_d     = state_q;
        filt_d      = '0;
        dly_d       = '0;
        stage_d     = stage_q;
        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    filt_d = (filt_q < FILT_MAX) ? filt_q + 1'b1 : filt_q;
                    if (filt_d == FILT_MAX) begin
                        state_d = RELEASE;
                        filt_d  = '0;
                    end
                end
            end
            RELEASE: begin
                dly_d = (dly_q < DLY_MAX) ? dly_q + 1'b1 : dly_q;
                if (dly_d == DLY_MAX) begin
                    dly_d   = '0;
                    stage_d = NUM_STAGES'({stage_q, 1'b1});
                    if (stage_d[NUM_STAGES-1]) state_d = RUN;
                end
            end
            RUN: begin
                if (soft_rst_req) begin
                    state_d = SOFT_HOLD;
                    stage_d = '0;
                end
            end
            SOFT_HOLD: begin
                dly_d = (dly_q < DLY_MAX) ? dly_q + 1'b1 : dly_q;
                if (dly_d == DLY_MAX) begin
                    dly_d   = '0;
                    state_d = RELEASE;
                end
            end
        endcase
        // Lock loss overrides everything, including a coincident soft request.
        if (state_q != WAIT_LOCK && !lock_s) begin
            state_d = WAIT_LOCK;
            stage_d = '0;
            dly_d   = '0;
            filt_d  = '0;
        end
    end

    always_ff @(posedge clock or negedge rst_s_n) begin
        if (!rst_s_n) begin
            lock_sync_q <= '0;
            state_q     <= WAIT_LOCK;
            filt_q      <= '0;
            dly_q       <= '0;
            stage_q     <= '0;
        end else begin
            lock_sync_q <= lock_sync_d;
            state_q     <= state_d;
            filt_q      <= filt_d;
            dly_q       <= dly_d;
            stage_q     <= stage_d;
        end
    end

    assign stage_rst_n = stage_q;
    assign ready       = (state_q == RUN);

`ifdef RST_SEQ_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYC + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG_CYC);

    logic [WW-1:0] wdog_q, wdog_d;
    logic          lock_timeout_q, lock_timeout_d;

    always_comb begin
        wdog_d         = (state_q != WAIT_LOCK) ? '0 : (wdog_q < WDOG_MAX) ? wdog_q + 1'b1 : wdog_q;
        lock_timeout_d = lock_timeout_q | (wdog_d == WDOG_MAX);
    end

    always_ff @(posedge clock or negedge rst_s_n) begin
        if (!rst_s_n) begin
            wdog_q         <= '0;
            lock_timeout_q <= 1'b0;
        end else begin
            wdog_q         <= wdog_d;
            lock_timeout_q <= lock_timeout_d;
        end
    end

    assign lock_timeout = lock_timeout_q;
`else
    assign lock_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: scoreboard bench for rst_sequencer (3 stages, 4-cycle stage delay, filter 8, watchdog 50).
module tb_rst_sequencer;

`ifdef RST_SEQ_WATCHDOG_EN
    localparam bit WDOG = 1'b1;
`else
    localparam bit WDOG = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       rst_n = 1'b0;
    logic       locked = 1'b1;
    logic       soft_rst_req = 1'b0;
    logic [2:0] stage_rst_n;
    logic       ready;
    logic       lock_timeout;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;
    int base;

    typedef struct {
        int         cyc;
        logic [2:0] st;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    rst_sequencer #(
        .NUM_STAGES (3),
        .STAGE_DLY  (4),
        .LOCK_FILT  (8),
        .WDOG_CYC   (50)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .locked       (locked),
        .soft_rst_req (soft_rst_req),
        .stage_rst_n  (stage_rst_n),
        .ready        (ready),
        .lock_timeout (lock_timeout)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void expect_at(int c, logic [2:0] st, logic rdy, string name);
        exp_t x;
        x.cyc = c; x.st = st; x.rdy = rdy; x.name = name;
        sb.push_back(x);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; locked = 1'b1; soft_rst_req = 1'b0;
        repeat (3) @(negedge clock);
        total++;
        if (stage_rst_n !== 3'b000) $display("FAIL reset_stage: stage_rst_n=%b expected 000", stage_rst_n); else passed++;
        total++;
        if (ready !== 1'b0) $display("FAIL reset_ready: ready=%b expected 0", ready); else passed++;
        total++;
        if (lock_timeout !== 1'b0) $display("FAIL reset_timeout: lock_timeout=%b expected 0", lock_timeout); else passed++;
    endtask

    task automatic test_power_up();
        rst_n = 1'b1;
        base = cyc;
        expect_at(base + 12, 3'b000, 1'b0, "pu_entry");
        expect_at(base + 15, 3'b000, 1'b0, "pu_pre0");
        expect_at(base + 16, 3'b001, 1'b0, "pu_s0");
        expect_at(base + 19, 3'b001, 1'b0, "pu_pre1");
        expect_at(base + 20, 3'b011, 1'b0, "pu_s1");
        expect_at(base + 23, 3'b011, 1'b0, "pu_pre2");
        expect_at(base + 24, 3'b111, 1'b1, "pu_run");
        repeat (26) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (stage_rst_n !== e.st || ready !== e.rdy)
                    $display("FAIL %s @%0d: stage_rst_n=%b ready=%b expected %b/%b", e.name, cyc, stage_rst_n, ready, e.st, e.rdy);
                else passed++;
            end
        end
    endtask

    task automatic test_lock_loss();
        locked = 1'b0;
        base = cyc;
        expect_at(base + 2, 3'b111, 1'b1, "ll_before");
        expect_at(base + 3, 3'b000, 1'b0, "ll_drop");
        repeat (5) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (stage_rst_n !== e.st || ready !== e.rdy)
                    $display("FAIL %s @%0d: stage_rst_n=%b ready=%b expected %b/%b", e.name, cyc, stage_rst_n, ready, e.st, e.rdy);
                else passed++;
            end
        end
        locked = 1'b1;
        base = cyc;
        expect_at(base + 13, 3'b000, 1'b0, "ll_pre0");
        expect_at(base + 14, 3'b001, 1'b0, "ll_s0");
        expect_at(base + 22, 3'b111, 1'b1, "ll_run");
        repeat (24) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (stage_rst_n !== e.st || ready !== e.rdy)
                    $display("FAIL %s @%0d: stage_rst_n=%b ready=%b expected %b/%b", e.name, cyc, stage_rst_n, ready, e.st, e.rdy);
                else passed++;
            end
        end
    endtask

    task automatic test_soft_reset();
        base = cyc;
        expect_at(base + 1,  3'b000, 1'b0, "sr_hold");
        expect_at(base + 4,  3'b000, 1'b0, "sr_hold_end");
        expect_at(base + 8,  3'b000, 1'b0, "sr_pre0");
        expect_at(base + 9,  3'b001, 1'b0, "sr_s0");
        expect_at(base + 11, 3'b001, 1'b0, "sr_ignored");
        expect_at(base + 12, 3'b001, 1'b0, "sr_ignored2");
        expect_at(base + 13, 3'b011, 1'b0, "sr_s1");
        expect_at(base + 17, 3'b111, 1'b1, "sr_run");
        for (int i = 0; i < 19; i++) begin
            soft_rst_req = (i == 0 || i == 10);
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (stage_rst_n !== e.st || ready !== e.rdy)
                    $display("FAIL %s @%0d: stage_rst_n=%b ready=%b expected %b/%b", e.name, cyc, stage_rst_n, ready, e.st, e.rdy);
                else passed++;
            end
        end
        soft_rst_req = 1'b0;
    endtask

    task automatic test_simultaneous();
        base = cyc;
        expect_at(base + 2,  3'b111, 1'b1, "sim_before");
        expect_at(base + 3,  3'b000, 1'b0, "sim_drop");
        expect_at(base + 14, 3'b000, 1'b0, "sim_pre0");
        expect_at(base + 15, 3'b001, 1'b0, "sim_s0");
        for (int i = 0; i < 16; i++) begin
            locked = (i != 0);
            soft_rst_req = (i == 2);
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (stage_rst_n !== e.st || ready !== e.rdy)
                    $display("FAIL %s @%0d: stage_rst_n=%b ready=%b expected %b/%b", e.name, cyc, stage_rst_n, ready, e.st, e.rdy);
                else passed++;
            end
        end
        soft_rst_req = 1'b0;
        rst_n = 1'b0;
        #1;
        total++;
        if (stage_rst_n !== 3'b000) $display("FAIL async_stage: stage_rst_n=%b expected 000", stage_rst_n); else passed++;
        total++;
        if (ready !== 1'b0) $display("FAIL async_ready: ready=%b expected 0", ready); else passed++;
        repeat (2) @(negedge clock);
        total++;
        if (stage_rst_n !== 3'b000 || ready !== 1'b0)
            $display("FAIL async_hold: stage_rst_n=%b ready=%b expected 000/0", stage_rst_n, ready);
        else passed++;
    endtask

    task automatic test_glitch();
        rst_n = 1'b0; locked = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        repeat (4) @(negedge clock);
        base = cyc;
        expect_at(base + 15, 3'b000, 1'b0, "gl_filter");
        expect_at(base + 16, 3'b000, 1'b0, "gl_entry");
        expect_at(base + 19, 3'b000, 1'b0, "gl_pre0");
        expect_at(base + 20, 3'b001, 1'b0, "gl_s0");
        expect_at(base + 28, 3'b111, 1'b1, "gl_run");
        for (int i = 0; i < 30; i++) begin
            locked = (i != 5);
            @(negedge clock);
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                total++;
                if (stage_rst_n !== e.st || ready !== e.rdy)
                    $display("FAIL %s @%0d: stage_rst_n=%b ready=%b expected %b/%b", e.name, cyc, stage_rst_n, ready, e.st, e.rdy);
                else passed++;
            end
        end
    endtask

    task automatic test_watchdog();
        rst_n = 1'b0; locked = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clock);
            if (i == 51 || i == 52 || i == 60) begin
                total++;
                if (lock_timeout !== (WDOG && i >= 52))
                    $display("FAIL wdog_%0d: lock_timeout=%b expected %b", i, lock_timeout, WDOG && i >= 52);
                else passed++;
            end
        end
        locked = 1'b1;
        repeat (30) @(negedge clock);
        total++;
        if (ready !== 1'b1 || stage_rst_n !== 3'b111)
            $display("FAIL wdog_seq: stage_rst_n=%b ready=%b expected 111/1", stage_rst_n, ready);
        else passed++;
        total++;
        if (lock_timeout !== WDOG) $display("FAIL wdog_sticky: lock_timeout=%b expected %b", lock_timeout, WDOG); else passed++;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_loss();
        test_soft_reset();
        test_simultaneous();
        test_glitch();
        test_watchdog();
        while (sb.size() > 0) begin
            e = sb.pop_front();
            total++;
            $display("FAIL %s: expectation never reached, expected %b/%b", e.name, e.st, e.rdy);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
